// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry
//  Description : Keypad operand entry. Collects NOPS BCD operands of up to
//                DIGITS digits, separated by operator keys, and ends with
//                enter. The completed entry is held until the consumer acks.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock; all state changes on the rising edge
//    reset      in   synchronous active-high reset
//    key_valid  in   one-cycle strobe qualifying key
//    key        in   4   0-9 digit, 10-13 operator, 14 backspace, 15 enter
//    ack        in   consumer accepts the completed entry
//    operands   out  NOPS*4*DIGITS  operand i in slice i, BCD, LS digit low
//    opcode     out  2   last accepted operator (key-10)
//    cur_idx    out  IW  operand currently being entered
//    digit_cnt  out  CW  digits held in the current operand
//    ready      out  entry complete, held until ack
//    ovf        out  sticky: a digit was dropped because the operand was full
//    err        out  one-cycle pulse after a rejected key
// ============================================================================
module operand_entry #(
    parameter int  DIGITS = 4,
    parameter int  NOPS   = 2,
    localparam int IW     = (NOPS > 2) ? $clog2(NOPS) : 1,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key,
    input  logic                     ack,
    output logic [NOPS*4*DIGITS-1:0] operands,
    output logic [1:0]               opcode,
    output logic [IW-1:0]            cur_idx,
    output logic [CW-1:0]            digit_cnt,
    output logic                     ready,
    output logic                     ovf,
    output logic                     err
);

    localparam int          W       = 4 * DIGITS;
    localparam logic [IW-1:0] C_LAST = IW'(NOPS - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DIGITS);

    typedef enum logic [0:0] {
        ST_ENTRY = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t                     r_state, w_state;
    logic [NOPS-1:0][W-1:0]     r_ops,   w_ops;
    logic [1:0]                 r_opcode, w_opcode;
    logic [IW-1:0]              r_idx,   w_idx;
    logic [CW-1:0]              r_cnt,   w_cnt;
    logic                       r_ready, w_ready;
    logic                       r_ovf,   w_ovf;
    logic                       r_err,   w_err;

    logic [W-1:0]               w_cur;      // operand selected by r_idx
    logic [W-1:0]               w_new;      // replacement value for it
    logic                       w_wr;       // write w_new into current slot
    logic [1:0]                 w_key_op;   // key - 10, wrapped to 2 bits

    logic                       w_is_digit, w_is_op, w_is_bs, w_is_enter;

    assign w_is_digit = (key < 4'd10);
    assign w_is_op    = (key >= 4'd10) && (key <= 4'd13);
    assign w_is_bs    = (key == 4'd14);
    assign w_is_enter = (key == 4'd15);
    // Operators 10..13 have low bits 2,3,0,1; adding 2 mod 4 maps them to 0..3.
    assign w_key_op   = key[1:0] + 2'd2;

    // Current-operand mux; loop compare avoids indexing past NOPS-1 when
    // NOPS is not a power of two.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NOPS; i++) begin
            if (IW'(i) == r_idx) begin
                w_cur = r_ops[i];
            end
        end
    end

    always_comb begin
        w_state  = r_state;
        w_ops    = r_ops;
        w_opcode = r_opcode;
        w_idx    = r_idx;
        w_cnt    = r_cnt;
        w_ready  = r_ready;
        w_ovf    = r_ovf;
        w_err    = 1'b0;
        w_new    = w_cur;
        w_wr     = 1'b0;

        case (r_state)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (r_cnt < C_FULL) begin
                            w_new = (w_cur << 4) | W'(key);
                            w_wr  = 1'b1;
                            w_cnt = r_cnt + 1'b1;
                        end else begin
                            // Full operand: drop the digit silently, flag it.
                            w_ovf = 1'b1;
                        end
                    end else if (w_is_op) begin
                        if ((r_cnt != '0) && (r_idx != C_LAST)) begin
                            w_opcode = w_key_op;
                            w_idx    = r_idx + 1'b1;
                            w_cnt    = '0;
                        end else if ((r_cnt == '0) && (r_idx != '0)) begin
                            // Operator typed again before any digit: correction.
                            w_opcode = w_key_op;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (w_is_bs) begin
                        if (r_cnt != '0) begin
                            w_new = w_cur >> 4;
                            w_wr  = 1'b1;
                            w_cnt = r_cnt - 1'b1;
                        end
                    end else if (w_is_enter) begin
                        if ((r_idx == C_LAST) && (r_cnt != '0)) begin
                            w_state = ST_DONE;
                            w_ready = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (ack) begin
                    // ack takes priority over any key arriving with it.
                    w_state  = ST_ENTRY;
                    w_ops    = '0;
                    w_opcode = '0;
                    w_idx    = '0;
                    w_cnt    = '0;
                    w_ready  = 1'b0;
                    w_ovf    = 1'b0;
                end else if (key_valid) begin
                    w_err = 1'b1;
                end
            end

            default: begin
                w_state = ST_ENTRY;
            end
        endcase

        if (w_wr) begin
            for (int i = 0; i < NOPS; i++) begin
                if (IW'(i) == r_idx) begin
                    w_ops[i] = w_new;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ENTRY;
            r_ops    <= '0;
            r_opcode <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ops    <= w_ops;
            r_opcode <= w_opcode;
            r_idx    <= w_idx;
            r_cnt    <= w_cnt;
            r_ready  <= w_ready;
            r_ovf    <= w_ovf;
            r_err    <= w_err;
        end
    end

    assign operands  = r_ops;
    assign opcode    = r_opcode;
    assign cur_idx   = r_idx;
    assign digit_cnt = r_cnt;
    assign ready     = r_ready;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_entry
//  Description : Self-checking bench for operand_entry (DIGITS=4, NOPS=2).
//                Directed vector table plus short hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key;
    logic        ack;
    logic [31:0] operands;
    logic [1:0]  opcode;
    logic [0:0]  cur_idx;
    logic [2:0]  digit_cnt;
    logic        ready;
    logic        ovf;
    logic        err;

    int checks = 0;
    int errors = 0;

    operand_entry #(.DIGITS(4), .NOPS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key       (key),
        .ack       (ack),
        .operands  (operands),
        .opcode    (opcode),
        .cur_idx   (cur_idx),
        .digit_cnt (digit_cnt),
        .ready     (ready),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  k;
        logic        a;
        logic [15:0] op0;
        logic [15:0] op1;
        logic [1:0]  opc;
        logic        idx;
        logic [2:0]  cnt;
        logic        rdy;
        logic        ov;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic kv, logic [3:0] k, logic a,
                                logic [15:0] op0, logic [15:0] op1,
                                logic [1:0] opc, logic idx, logic [2:0] cnt,
                                logic rdy, logic ov, logic er);
        vec_t v;
        v.rst = rst; v.kv = kv; v.k = k; v.a = a;
        v.op0 = op0; v.op1 = op1; v.opc = opc; v.idx = idx; v.cnt = cnt;
        v.rdy = rdy; v.ov = ov; v.er = er;
        return v;
    endfunction

    // Layout: op1, op0, opcode, cur_idx, digit_cnt, ready, ovf, err
    function automatic logic [40:0] pack(logic [15:0] op0, logic [15:0] op1,
                                         logic [1:0] opc, logic idx,
                                         logic [2:0] cnt, logic rdy,
                                         logic ov, logic er);
        return {op1, op0, opc, idx, cnt, rdy, ov, er};
    endfunction

    task automatic check(input string name, input logic [40:0] exp);
        logic [40:0] act;
        act = {operands[31:16], operands[15:0], opcode, cur_idx, digit_cnt,
               ready, ovf, err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got op1=%h op0=%h opc=%0d idx=%0d cnt=%0d rdy=%b ovf=%b err=%b, expected op1=%h op0=%h opc=%0d idx=%0d cnt=%0d rdy=%b ovf=%b err=%b",
                     name, act[40:25], act[24:9], act[8:7], act[6], act[5:3],
                     act[2], act[1], act[0], exp[40:25], exp[24:9], exp[8:7],
                     exp[6], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic rst, input logic kv, input logic [3:0] k,
                        input logic a);
        reset = rst; key_valid = kv; key = k; ack = a;
        @(posedge clk);
        #1;
        reset = 1'b0; key_valid = 1'b0; key = 4'd0; ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key = 4'd0; ack = 1'b0;

        //               rst kv key  ack  op0      op1    opc idx cnt rdy ovf err
        vecs.push_back(mk(1, 0, 4'd0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 1, 4'd1, 0, 16'h0001, 16'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd2, 0, 16'h0012, 16'h0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd3, 0, 16'h0123, 16'h0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd4, 0, 16'h1234, 16'h0, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd5, 0, 16'h1234, 16'h0, 0, 0, 4, 0, 1, 0)); // overflow
        vecs.push_back(mk(0, 0, 4'd9, 0, 16'h1234, 16'h0, 0, 0, 4, 0, 1, 0)); // key ignored w/o valid
        vecs.push_back(mk(0, 1, 4'd14,0, 16'h0123, 16'h0, 0, 0, 3, 0, 1, 0)); // backspace
        vecs.push_back(mk(0, 1, 4'd11,0, 16'h0123, 16'h0, 1, 1, 0, 0, 1, 0)); // operator
        vecs.push_back(mk(0, 1, 4'd12,0, 16'h0123, 16'h0, 2, 1, 0, 0, 1, 0)); // correction
        vecs.push_back(mk(0, 1, 4'd15,0, 16'h0123, 16'h0, 2, 1, 0, 0, 1, 1)); // enter, empty op
        vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0123, 16'h0, 2, 1, 0, 0, 1, 0)); // err drops
        vecs.push_back(mk(0, 1, 4'd14,0, 16'h0123, 16'h0, 2, 1, 0, 0, 1, 0)); // bs on empty
        vecs.push_back(mk(0, 1, 4'd9, 0, 16'h0123, 16'h9, 2, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 4'd13,0, 16'h0123, 16'h9, 2, 1, 1, 0, 1, 1)); // op at last
        vecs.push_back(mk(0, 0, 4'd0, 1, 16'h0123, 16'h9, 2, 1, 1, 0, 1, 0)); // ack in ENTRY
        vecs.push_back(mk(0, 1, 4'd15,0, 16'h0123, 16'h9, 2, 1, 1, 1, 1, 0)); // DONE
        vecs.push_back(mk(0, 1, 4'd3, 0, 16'h0123, 16'h9, 2, 1, 1, 1, 1, 1)); // key in DONE
        vecs.push_back(mk(0, 1, 4'd3, 1, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0)); // ack + key
        vecs.push_back(mk(0, 1, 4'd7, 0, 16'h0007, 16'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd10,0, 16'h0007, 16'h0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd12,0, 16'h0007, 16'h0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd9, 0, 16'h0007, 16'h9, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd15,0, 16'h0007, 16'h9, 2, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'd8, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0)); // reset in DONE
        vecs.push_back(mk(0, 1, 4'd4, 0, 16'h0004, 16'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd5, 0, 16'h0045, 16'h0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd14,0, 16'h0004, 16'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd14,0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd14,0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd15,0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 1)); // enter at idx 0
        vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd10,0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 1)); // op at idx 0 empty
        vecs.push_back(mk(0, 1, 4'd8, 0, 16'h0008, 16'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd8, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 0)); // reset mid-entry

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].kv, vecs[i].k, vecs[i].a);
            check($sformatf("vec%0d", i),
                  pack(vecs[i].op0, vecs[i].op1, vecs[i].opc, vecs[i].idx,
                       vecs[i].cnt, vecs[i].rdy, vecs[i].ov, vecs[i].er));
        end

        // Sticky ovf survives the move to the next operand and clears on ack.
        step(1, 0, 4'd0, 0);
        step(0, 1, 4'd1, 0);
        step(0, 1, 4'd2, 0);
        step(0, 1, 4'd3, 0);
        step(0, 1, 4'd4, 0);
        step(0, 1, 4'd5, 0);
        check("seq_ovf_full", pack(16'h1234, 16'h0, 2'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
        step(0, 1, 4'd13, 0);
        check("seq_ovf_op", pack(16'h1234, 16'h0, 2'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0));
        step(0, 1, 4'd6, 0);
        check("seq_op1_digit", pack(16'h1234, 16'h6, 2'd3, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0));
        step(0, 1, 4'd15, 0);
        check("seq_done", pack(16'h1234, 16'h6, 2'd3, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0));
        // Ready holds while no ack arrives.
        step(0, 0, 4'd0, 0);
        step(0, 0, 4'd0, 0);
        check("seq_hold", pack(16'h1234, 16'h6, 2'd3, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0));
        // Back-to-back rejected keys in DONE: err follows each one.
        step(0, 1, 4'd1, 0);
        check("seq_done_err1", pack(16'h1234, 16'h6, 2'd3, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1));
        step(0, 0, 4'd0, 0);
        check("seq_done_err0", pack(16'h1234, 16'h6, 2'd3, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0));
        step(0, 0, 4'd0, 1);
        check("seq_ack_clear", pack(16'h0000, 16'h0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
